// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO register pair.
// Accepts one mult/div/mthi/mtlo per issue. mult/div run for a fixed number
// of cycles and commit HI/LO on the edge where busy falls. A cancelled
// E-stage op is never accepted, so it never touches HI/LO.
module md_sequencer #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        cancel,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6
  } op_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  op_t         op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic [63:0] prod_s, prod_u;
  logic [31:0] den, mag_a, mag_b, uq_s, ur_s, quo_s, rem_s, quo_u, rem_u;

  // Results computed combinationally from the latched operands.
  // Signed divide goes through magnitudes so that 0x80000000 / -1 wraps to
  // 0x80000000 with a zero remainder instead of overflowing the divider.
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    den    = (b_q == '0) ? 32'd1 : b_q;
    mag_a  = a_q[31] ? (~a_q + 32'd1) : a_q;
    mag_b  = den[31] ? (~den + 32'd1) : den;
    uq_s   = mag_a / mag_b;
    ur_s   = mag_a % mag_b;
    quo_s  = (a_q[31] ^ b_q[31]) ? (~uq_s + 32'd1) : uq_s;
    rem_s  = a_q[31] ? (~ur_s + 32'd1) : ur_s;
    quo_u  = a_q / den;
    rem_u  = a_q % den;
  end

  // Acceptance, next-state and commit logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    start   = 1'b0;
    accept  = ~reset & ~cancel & (state_q == IDLE) && (op >= 4'd1) && (op <= 4'd6);
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              start   = 1'b1;
              a_d     = rs;
              b_d     = rt;
              op_d    = op_t'(op);
              state_d = RUN;
              if (op == OP_MULT || op == OP_MULTU) cnt_d = 4'(MUL_CYCLES - 1);
              else                                  cnt_d = 4'(DIV_CYCLES - 1);
            end
            OP_MTHI: hi_d = rs;
            OP_MTLO: lo_d = rs;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV:   if (b_q != '0) {hi_d, lo_d} = {rem_s, quo_s};
            OP_DIVU:  if (b_q != '0) {hi_d, lo_d} = {rem_u, quo_u};
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NONE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Testbench for md_sequencer: directed scenarios plus randomized ops checked
// against an arithmetic reference model of HI/LO and busy duration.
module tb_md_sequencer;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] rs, rt;
  logic        cancel;
  logic        start, busy, start1, busy1;
  logic [31:0] hi, lo, hi1, lo1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  md_sequencer #(.MUL_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk(clk), .reset(reset), .op(op), .rs(rs), .rt(rt), .cancel(cancel),
    .start(start), .busy(busy), .hi(hi), .lo(lo)
  );

  md_sequencer #(.MUL_CYCLES(1), .DIV_CYCLES(15)) u_dut1 (
    .clk(clk), .reset(reset), .op(op), .rs(rs), .rt(rt), .cancel(cancel),
    .start(start1), .busy(busy1), .hi(hi1), .lo(lo1)
  );

  // Reference: new {HI,LO} after an accepted op, using 64-bit integer math.
  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] res;
    res = {h, l};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (o)
      OP_MULT:  res = 64'(sa * sb);
      OP_MULTU: res = ua * ub;
      OP_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      OP_DIVU:  if (b != 0) res = {32'(ua % ub), 32'(ua / ub)};
      OP_MTHI:  res = {a, l};
      OP_MTLO:  res = {h, a};
      default: ;
    endcase
    return res;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one op and follow it to completion. junk: 0 quiet, 1 random traffic
  // while busy, 2 mtlo 0xAAAA while busy, 3 cancel pulse in 2nd busy cycle.
  task automatic do_op(input string name, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic c, input int junk);
    logic acc, md;
    int exp_n, n;
    logic [63:0] exp;
    acc   = !c && (o >= 1) && (o <= 6);
    md    = acc && (o <= 4);
    exp_n = (o <= 2) ? 5 : 10;
    exp   = acc ? ref_result(o, a, b, m_hi, m_lo) : {m_hi, m_lo};
    op = o; rs = a; rt = b; cancel = c;
    #1;
    n_checks++;
    if (start !== md) begin
      n_fail++;
      $display("FAIL %s start: got %b expected %b", name, start, md);
    end
    tick;
    op = 4'd0; cancel = 1'b0;
    if (md) begin
      n = 0;
      while (busy === 1'b1 && n < 40) begin
        n_checks++;
        if (hi !== m_hi || lo !== m_lo) begin
          n_fail++;
          $display("FAIL %s hold: got %h_%h expected %h_%h", name, hi, lo, m_hi, m_lo);
        end
        n++;
        case (junk)
          1: begin op = 4'($urandom); rs = $urandom; rt = $urandom; cancel = 1'($urandom); end
          2: begin op = OP_MTLO; rs = 32'hAAAA; end
          3: cancel = (n == 2);
          default: ;
        endcase
        tick;
        op = 4'd0; cancel = 1'b0;
      end
      n_checks++;
      if (n !== exp_n) begin
        n_fail++;
        $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, exp_n);
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_end: got %b expected 0", name, busy);
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    n_checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL %s result: got %h_%h expected %h_%h", name, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; op = OP_MULT; rs = 32'd1; rt = 32'd1; cancel = 1'b0;
    repeat (3) tick;
    n_checks++;
    if (start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start: got %b expected 0", start);
    end
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
    end
    reset = 1'b0; op = 4'd0;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_param_one;
    int n0, n1, k;
    logic [63:0] exp;
    op = OP_MULT; rs = 32'd3; rt = 32'hFFFFFFFC;
    exp = ref_result(OP_MULT, 32'd3, 32'hFFFFFFFC, m_hi, m_lo);
    #1;
    n_checks++;
    if (start !== 1'b1 || start1 !== 1'b1) begin
      n_fail++;
      $display("FAIL p1_start: got %b/%b expected 1/1", start, start1);
    end
    tick;
    op = 4'd0;
    n_checks++;
    if (busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL p1_busy: got %b expected 1", busy1);
    end
    tick;
    n_checks++;
    if (busy1 !== 1'b0 || hi1 !== 32'hFFFFFFFF || lo1 !== 32'hFFFFFFF4) begin
      n_fail++;
      $display("FAIL p1_commit: got busy=%b %h_%h expected 0 ffffffff_fffffff4", busy1, hi1, lo1);
    end
    k = 0;
    while (busy === 1'b1 && k < 40) begin tick; k++; end
    m_hi = exp[63:32]; m_lo = exp[31:0];
    n_checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL p1_dut0: got busy=%b %h_%h expected 0 %h_%h", busy, hi, lo, m_hi, m_lo);
    end
    // Max-length divide on the second instance alongside the default one.
    op = OP_DIV; rs = 32'd1000; rt = 32'hFFFFFFFD;
    exp = ref_result(OP_DIV, 32'd1000, 32'hFFFFFFFD, m_hi, m_lo);
    tick;
    op = 4'd0;
    n0 = 0; n1 = 0; k = 0;
    while ((busy === 1'b1 || busy1 === 1'b1) && k < 40) begin
      if (busy === 1'b1) n0++;
      if (busy1 === 1'b1) n1++;
      tick;
      k++;
    end
    n_checks++;
    if (n0 !== 10 || n1 !== 15) begin
      n_fail++;
      $display("FAIL p15_cycles: got %0d/%0d expected 10/15", n0, n1);
    end
    n_checks++;
    if (hi1 !== 32'd1 || lo1 !== 32'hFFFFFEB3) begin
      n_fail++;
      $display("FAIL p15_result: got %h_%h expected 00000001_fffffeb3", hi1, lo1);
    end
    m_hi = exp[63:32]; m_lo = exp[31:0];
    n_checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL p15_dut0: got %h_%h expected %h_%h", hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_mult;
    do_op("mult", OP_MULT, 32'hFFFFFFFF, 32'd2, 1'b0, 0);
    n_checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin
      n_fail++;
      $display("FAIL mult_const: got %h_%h expected ffffffff_fffffffe", hi, lo);
    end
    do_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 0);
    n_checks++;
    if (hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin
      n_fail++;
      $display("FAIL multu_const: got %h_%h expected 00000001_fffffffe", hi, lo);
    end
  endtask

  task automatic test_div;
    do_op("div", OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 0);
    n_checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      n_fail++;
      $display("FAIL div_const: got %h_%h expected ffffffff_fffffffd", hi, lo);
    end
    do_op("divu", OP_DIVU, 32'd7, 32'd2, 1'b0, 0);
    n_checks++;
    if (hi !== 32'd1 || lo !== 32'd3) begin
      n_fail++;
      $display("FAIL divu_const: got %h_%h expected 00000001_00000003", hi, lo);
    end
    do_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'h80000000) begin
      n_fail++;
      $display("FAIL div_ovf_const: got %h_%h expected 00000000_80000000", hi, lo);
    end
  endtask

  task automatic test_divzero;
    do_op("mthi", OP_MTHI, 32'h12345678, 32'd0, 1'b0, 0);
    do_op("mtlo", OP_MTLO, 32'h9ABCDEF0, 32'd0, 1'b0, 0);
    do_op("div0", OP_DIV, 32'd5, 32'd0, 1'b0, 0);
    do_op("divu0", OP_DIVU, 32'd5, 32'd0, 1'b0, 0);
    n_checks++;
    if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
      n_fail++;
      $display("FAIL div0_const: got %h_%h expected 12345678_9abcdef0", hi, lo);
    end
  endtask

  task automatic test_cancel;
    do_op("mult_cancel", OP_MULT, 32'd9, 32'd9, 1'b1, 0);
    do_op("mthi_cancel", OP_MTHI, 32'hDEADBEEF, 32'd0, 1'b1, 0);
    do_op("mult_run_cancel", OP_MULT, 32'd7, 32'd6, 1'b0, 3);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd42) begin
      n_fail++;
      $display("FAIL run_cancel_const: got %h_%h expected 00000000_0000002a", hi, lo);
    end
  endtask

  task automatic test_back_to_back;
    do_op("mult_mtlo_busy", OP_MULT, 32'h10000, 32'h10000, 1'b0, 2);
    do_op("mtlo_after", OP_MTLO, 32'hAAAA, 32'd0, 1'b0, 0);
    n_checks++;
    if (hi !== 32'd1 || lo !== 32'hAAAA) begin
      n_fail++;
      $display("FAIL b2b_const: got %h_%h expected 00000001_0000aaaa", hi, lo);
    end
    do_op("b2b_div", OP_DIV, 32'd100, 32'hFFFFFFF9, 1'b0, 0);
    do_op("b2b_multu", OP_MULTU, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 0);
  endtask

  task automatic test_random;
    logic [3:0]  o;
    logic [31:0] a, b;
    logic        c;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 8));
      if ($urandom_range(0, 9) == 0) o = 4'($urandom_range(7, 15));
      a = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      c = ($urandom_range(0, 4) == 0);
      do_op("random", o, a, b, c, 1);
    end
  endtask

  task automatic test_reset_mid_run;
    logic bad;
    do_op("mthi_pre", OP_MTHI, 32'hDEAD0001, 32'd0, 1'b0, 0);
    do_op("mtlo_pre", OP_MTLO, 32'hDEAD0002, 32'd0, 1'b0, 0);
    op = OP_DIV; rs = 32'd100; rt = 32'd7;
    tick;
    op = 4'd0;
    tick;
    tick;
    reset = 1'b1;
    tick;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: got busy=%b %h_%h expected 0 0_0", busy, hi, lo);
    end
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    bad = 1'b0;
    repeat (15) begin
      tick;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_no_commit: got late activity=%b expected 0 (hi=%h lo=%h)", bad, hi, lo);
    end
  endtask

  initial begin
    reset = 1'b1; op = 4'd0; rs = '0; rt = '0; cancel = 1'b0;
    m_hi = '0; m_lo = '0;
    #1;
    test_reset;
    test_param_one;
    test_mult;
    test_div;
    test_divzero;
    test_cancel;
    test_back_to_back;
    test_random;
    test_reset_mid_run;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle multiply/divide sequencer for the E stage, owning the HI/LO register pair. It accepts one mult/div/mthi/mtlo operation per issue and runs mult/div for a fixed, parameterised number of cycles. It exposes `start`/`busy` to the forwarding/stall controller, which stalls dependent instructions. It honours an interrupt/exception cancel so that a squashed E-stage instruction never modifies HI/LO.

## Interface

Parameters:
- `MUL_CYCLES`, default 5: busy cycles for mult/multu; legal range 1–15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1–15.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `op` input 4: operation select. Encoding: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo. Codes 7–15 are treated as none.
- `rs` input 32: operand A (dividend, multiplicand, or mthi/mtlo source), already forwarded.
- `rt` input 32: operand B (divisor or multiplier), already forwarded.
- `cancel` input 1: E-stage instruction is being squashed (interrupt request or exception this cycle).
- `start` output 1: combinational; high in the cycle a mult/div is accepted.
- `busy` output 1: registered; high while a mult/div is in flight.
- `hi` output 32: registered committed HI.
- `lo` output 32: registered committed LO.

## Operation

- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, with a 4-bit down-counter `cnt`.
- Accept condition: `accept = (state==IDLE) & ~cancel & (op in 1..6)`.
  - `op` presented while in RUN is ignored. The stall controller guarantees it is re-presented later.
- mult/div accept:
  - `start`=1 in the same cycle.
  - Operands and op are latched at the edge.
  - Next state is RUN with `cnt` = `MUL_CYCLES-1` or `DIV_CYCLES-1`.
- mthi/mtlo accept:
  - `hi` or `lo` is loaded with `rs` at the edge.
  - No busy; state stays IDLE; `start`=0.
- RUN: `cnt` decrements each edge. At the edge where `cnt`==0:
  - HI/LO are committed.
  - State returns to IDLE, so `busy` falls.
- Arithmetic on latched operands:
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = signed quotient, truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - Divisor 0 (div or divu): HI/LO are left unchanged at commit.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- `cancel`:
  - Blocks acceptance in the same cycle, including mthi/mtlo.
  - Has no effect on an op already in RUN; it completes and commits normally.
- Result computation is free to be combinational on the latched operands. Only commit timing is specified.

## Timing

- Reset: state IDLE, `busy`=0, `hi`=0, `lo`=0, `cnt`=0, latched operands 0.
  - `start` is 0 during reset because acceptance is gated by reset.
- Reset mid-RUN: the next edge returns to IDLE with HI/LO cleared; no commit occurs.
- mult accepted at edge T0 (`start`=1 in the cycle before T0):
  - `busy`=1 for exactly `MUL_CYCLES` cycles after T0.
  - HI/LO take new values at edge T0+`MUL_CYCLES`, which is the same edge where `busy` falls.
- div: as above with `DIV_CYCLES`.
- Total stall window seen by the controller is `start|busy`, `MUL_CYCLES`+1 cycles. Reading `hi`/`lo` once `start|busy` is low returns the committed result.
- mthi/mtlo: value visible on `hi`/`lo` in the cycle after the accept edge.
- Back-to-back: a new op may be accepted in the first cycle where `busy`=0, which is the cycle immediately after commit.
- Parameter value 1: RUN lasts one cycle and commit happens at the edge after accept+1.

## Test plan

- Reset, then mult with rs=0xFFFFFFFF, rt=2:
  - `start` pulses for 1 cycle.
  - `busy` is high for 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - Repeating with multu gives hi=0x00000001, lo=0xFFFFFFFE.
- div with rs=0xFFFFFFF9 (−7), rt=2:
  - `busy` is high for 10 cycles.
  - Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu with rs=7, rt=2 gives lo=3, hi=1.
- Divide by zero: mthi 0x12345678, mtlo 0x9ABCDEF0, then div rs=5, rt=0. After 10 busy cycles, hi/lo remain 0x12345678/0x9ABCDEF0.
- Cancel:
  - mult issued with `cancel`=1 gives `start`=0, `busy` stays 0, hi/lo unchanged.
  - mult accepted, then `cancel` pulsed during RUN: the result still commits after 5 cycles.
- Ops during busy and back-to-back:
  - mtlo 0xAAAA presented while `busy`: ignored, lo unchanged.
  - Re-presented the cycle after commit: lo=0xAAAA on the next cycle.
- Reset mid-RUN: assert `reset` in the 3rd busy cycle of a div. The next cycle shows `busy`=0, hi=0, lo=0, and no later commit occurs.
